// File: rtl/alu_bus_arbiter.sv
// Registered request/grant arbiter for the shared ALU/databus: timer set (0), time update (1), timer compare (2).
// Optional per-owner hold timeout is enabled by defining ARB_TIMEOUT_EN.
module alu_bus_arbiter #(
  parameter int unsigned       OP_W     = 2,
  parameter logic [OP_W-1:0]   IDLE_OP  = '0,
  parameter int unsigned       MAX_HOLD = 16
) (
  input  logic            i_clk,
  input  logic            i_clear,
  input  logic [2:0]      i_req,
  input  logic [OP_W-1:0] i_s0,
  input  logic [OP_W-1:0] i_s1,
  input  logic [OP_W-1:0] i_s2,
  output logic [2:0]      o_gnt,
  output logic [1:0]      o_owner,
  output logic [OP_W-1:0] o_alu_s,
  output logic            o_bus_busy,
  output logic            o_timeout_err
);

  // state      | meaning
  // ST_IDLE    | bus free, arbitrate on any request
  // ST_GRANT   | one owner holds the bus until it drops req (or times out)
  // ST_RELEASE | one turnaround cycle, bus free, pending requests arbitrated
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] OWNER_NONE = 2'b11;

  state_t          r_state;
  logic [2:0]      r_gnt;
  logic [1:0]      r_owner;
  logic [OP_W-1:0] r_alu_s;
  logic            r_busy;
  logic            r_rr_ptr;

  logic [2:0]      w_req_eff;
  logic            w_any_req;
  logic [1:0]      w_win;
  logic [2:0]      w_win_gnt;
  logic [OP_W-1:0] w_win_s;
  logic [OP_W-1:0] w_own_s;
  logic            w_own_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold;
  logic [2:0] r_mask;
  logic       r_timeout_err;

  assign w_req_eff     = i_req & ~r_mask;
  assign o_timeout_err = r_timeout_err;
`else
  assign w_req_eff     = i_req;
  assign o_timeout_err = 1'b0;
`endif

  assign w_any_req = |w_req_eff;

  // Update always wins; set and compare alternate through r_rr_ptr.
  always_comb begin
    w_win = OWNER_NONE;
    if (w_req_eff[1]) begin
      w_win = 2'd1;
    end else if (w_req_eff[0] && w_req_eff[2]) begin
      w_win = r_rr_ptr ? 2'd2 : 2'd0;
    end else if (w_req_eff[0]) begin
      w_win = 2'd0;
    end else if (w_req_eff[2]) begin
      w_win = 2'd2;
    end
  end

  always_comb begin
    w_win_gnt = 3'b000;
    w_win_s   = IDLE_OP;
    case (w_win)
      2'd0: begin
        w_win_gnt = 3'b001;
        w_win_s   = i_s0;
      end
      2'd1: begin
        w_win_gnt = 3'b010;
        w_win_s   = i_s1;
      end
      2'd2: begin
        w_win_gnt = 3'b100;
        w_win_s   = i_s2;
      end
      default: begin
        w_win_gnt = 3'b000;
        w_win_s   = IDLE_OP;
      end
    endcase
  end

  always_comb begin
    w_own_req = 1'b0;
    w_own_s   = IDLE_OP;
    case (r_owner)
      2'd0: begin
        w_own_req = i_req[0];
        w_own_s   = i_s0;
      end
      2'd1: begin
        w_own_req = i_req[1];
        w_own_s   = i_s1;
      end
      2'd2: begin
        w_own_req = i_req[2];
        w_own_s   = i_s2;
      end
      default: begin
        w_own_req = 1'b0;
        w_own_s   = IDLE_OP;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 3'b000;
      r_owner  <= OWNER_NONE;
      r_alu_s  <= IDLE_OP;
      r_busy   <= 1'b0;
      r_rr_ptr <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold        <= 8'd0;
      r_mask        <= 3'b000;
      r_timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      // A timed-out requester stays masked until it lets go of req.
      r_timeout_err <= 1'b0;
      r_mask        <= r_mask & i_req;
`endif
      unique case (r_state)
        ST_IDLE, ST_RELEASE: begin
          if (w_any_req) begin
            r_state <= ST_GRANT;
            r_gnt   <= w_win_gnt;
            r_owner <= w_win;
            r_alu_s <= w_win_s;
            r_busy  <= 1'b1;
            if (w_win == 2'd0) begin
              r_rr_ptr <= 1'b1;
            end else if (w_win == 2'd2) begin
              r_rr_ptr <= 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            r_hold <= 8'd0;
`endif
          end else begin
            r_state <= ST_IDLE;
            r_gnt   <= 3'b000;
            r_owner <= OWNER_NONE;
            r_alu_s <= IDLE_OP;
            r_busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!w_own_req) begin
            r_state <= ST_RELEASE;
            r_gnt   <= 3'b000;
            r_owner <= OWNER_NONE;
            r_alu_s <= IDLE_OP;
            r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          end else if (r_hold == HOLD_LAST) begin
            r_state       <= ST_RELEASE;
            r_gnt         <= 3'b000;
            r_owner       <= OWNER_NONE;
            r_alu_s       <= IDLE_OP;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_mask        <= (r_mask & i_req) | r_gnt;
`endif
          end else begin
            r_alu_s <= w_own_s;
`ifdef ARB_TIMEOUT_EN
            r_hold  <= r_hold + 8'd1;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 3'b000;
          r_owner <= OWNER_NONE;
          r_alu_s <= IDLE_OP;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt      = r_gnt;
  assign o_owner    = r_owner;
  assign o_alu_s    = r_alu_s;
  assign o_bus_busy = r_busy;

endmodule
